// File: rtl/ecc_serial_rx_pkg.sv
// rtl/ecc_serial_rx_pkg.sv - shared ECC receiver constants, state encoding and mode decode
// Contents: default word width and lane count, 2-bit key-length mode
// encodings, receiver FSM state type, mode-to-length decode function.
package ecc_serial_rx_pkg;

    localparam int ECC_MAX_BITS = 128;
    localparam int ECC_LANES    = 5;

    localparam logic [1:0] BITS16  = 2'b00;
    localparam logic [1:0] BITS32  = 2'b01;
    localparam logic [1:0] BITS64  = 2'b10;
    localparam logic [1:0] BITS128 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MODE1 = 3'd1,
        ST_MODE0 = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } rx_state_t;

    // Operand length in bits for a given key-length mode.
    function automatic logic [7:0] mode_to_nbits(input logic [1:0] mode);
        logic [7:0] nbits;
        case (mode)
            BITS16:  nbits = 8'd16;
            BITS32:  nbits = 8'd32;
            BITS64:  nbits = 8'd64;
            default: nbits = 8'd128;
        endcase
        return nbits;
    endfunction

endpackage

// File: rtl/ecc_shift_lane.sv
// rtl/ecc_shift_lane.sv - one MAX_BITS serial-in shift register with clear and shift enable
// Ports: clk, rst (async active-low), i_clear (zero the word, wins over
// shift), i_shift (shift left, insert i_bit at bit 0), i_bit, o_word.
module ecc_shift_lane
    import ecc_serial_rx_pkg::*;
#(
    parameter int MAX_BITS = ECC_MAX_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clear,
    input  logic                i_shift,
    input  logic                i_bit,
    output logic [MAX_BITS-1:0] o_word
);

    logic [MAX_BITS-1:0] r_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word <= '0;
        end else if (i_clear) begin
            r_word <= '0;
        end else if (i_shift) begin
            r_word <= {r_word[MAX_BITS-2:0], i_bit};
        end
    end

    assign o_word = r_word;

endmodule

// File: rtl/ecc_serial_rx.sv
// rtl/ecc_serial_rx.sv - bit-serial ECC operand frame receiver
// Frame: start pulse on i_valid, two mode bits on i_mode (MSB first), then
// N cycles of one bit per lane on i_lane (MSB first).
// Ports: clk, rst (async active-low), i_valid, i_mode, i_lane[LANES],
// o_busy (receiving), o_done (one-cycle completion pulse), o_mode,
// o_nbits (16/32/64/128), o_data (lane k at [k*MAX_BITS +: MAX_BITS]).
module ecc_serial_rx
    import ecc_serial_rx_pkg::*;
#(
    parameter int MAX_BITS = ECC_MAX_BITS,
    parameter int LANES    = ECC_LANES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    input  logic                      i_mode,
    input  logic [LANES-1:0]          i_lane,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [1:0]                o_mode,
    output logic [7:0]                o_nbits,
    output logic [LANES*MAX_BITS-1:0] o_data
);

    rx_state_t  r_state;
    rx_state_t  w_next;
    logic       w_clear;
    logic       w_shift;
    logic [7:0] w_nbits_new;
    logic [7:0] r_cnt;
    logic [1:0] r_mode;
    logic [7:0] r_nbits;
    logic       r_busy;
    logic       r_done;

    // Length decoded from the mode bit being latched in MODE0.
    assign w_nbits_new = mode_to_nbits({r_mode[1], i_mode});
    assign w_shift     = (r_state == ST_SHIFT);

    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    w_next  = ST_MODE1;
                    w_clear = 1'b1;
                end
            end
            ST_MODE1: w_next = ST_MODE0;
            ST_MODE0: w_next = ST_SHIFT;
            ST_SHIFT: begin
                if (r_cnt == 8'd0) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // A start pulse in the DONE cycle begins the next frame
                // immediately, so o_data is only valid while o_done is high.
                if (i_valid) begin
                    w_next  = ST_MODE1;
                    w_clear = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            // Status flags are registered from the next state so they line
            // up exactly with the state they describe.
            r_busy  <= (w_next == ST_MODE1) || (w_next == ST_MODE0) || (w_next == ST_SHIFT);
            r_done  <= (w_next == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode  <= BITS128;
            r_nbits <= 8'd128;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                ST_MODE1: r_mode[1] <= i_mode;
                ST_MODE0: begin
                    r_mode[0] <= i_mode;
                    r_nbits   <= w_nbits_new;
                    r_cnt     <= w_nbits_new - 8'd1;
                end
                ST_SHIFT: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        ecc_shift_lane #(
            .MAX_BITS (MAX_BITS)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_clear (w_clear),
            .i_shift (w_shift),
            .i_bit   (i_lane[k]),
            .o_word  (o_data[k*MAX_BITS +: MAX_BITS])
        );
    end

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_mode  = r_mode;
    assign o_nbits = r_nbits;

endmodule

// File: tb/tb_ecc_serial_rx.sv
// tb/tb_ecc_serial_rx.sv - self-checking bench for ecc_serial_rx
module tb_ecc_serial_rx;

    localparam int MB = 128;
    localparam int NL = 5;
    localparam int DW = MB * NL;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic          i_mode;
    logic [NL-1:0] i_lane;
    logic          o_busy;
    logic          o_done;
    logic [1:0]    o_mode;
    logic [7:0]    o_nbits;
    logic [DW-1:0] o_data;

    int n_total = 0;
    int n_bad   = 0;

    logic [MB-1:0] fv [NL];
    logic [DW-1:0] last_exp;

    ecc_serial_rx #(
        .MAX_BITS (MB),
        .LANES    (NL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_mode  (i_mode),
        .i_lane  (i_lane),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_mode  (o_mode),
        .o_nbits (o_nbits),
        .o_data  (o_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [MB-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: each lane holds the low N bits of its value, zero-extended.
    function automatic logic [DW-1:0] model_data(input int n);
        logic [DW-1:0] d;
        logic [MB-1:0] mask;
        d    = '0;
        mask = (n >= MB) ? {MB{1'b1}} : ((MB'(1) << n) - MB'(1));
        for (int k = 0; k < NL; k++) begin
            d[k*MB +: MB] = fv[k] & mask;
        end
        return d;
    endfunction

    // Entered and left at a falling edge; returns inside the o_done cycle.
    task automatic run_frame(input logic [1:0] mode, input bit glitch, input string tag);
        int n;
        int bsy;
        int dn;
        n   = 16 << mode;
        bsy = 0;
        dn  = 0;
        i_valid = 1'b1;
        i_mode  = 1'bx;
        @(negedge clk);
        i_valid = 1'b0;
        chk({tag, "/clear"}, o_data, '0);
        bsy += int'(o_busy);
        dn  += int'(o_done);
        i_mode = mode[1];
        @(negedge clk);
        bsy += int'(o_busy);
        dn  += int'(o_done);
        i_mode = mode[0];
        @(negedge clk);
        bsy += int'(o_busy);
        dn  += int'(o_done);
        for (int i = n - 1; i >= 0; i--) begin
            i_mode  = glitch ? 1'bx : 1'($urandom);
            i_valid = glitch && (i == n / 2);
            for (int k = 0; k < NL; k++) begin
                i_lane[k] = fv[k][i];
            end
            @(negedge clk);
            if (i != 0) begin
                bsy += int'(o_busy);
                dn  += int'(o_done);
            end
        end
        i_valid  = 1'b0;
        i_mode   = 1'bx;
        i_lane   = NL'($urandom);
        last_exp = model_data(n);
        chk({tag, "/busy_cycles"}, DW'(bsy), DW'(n + 2));
        chk({tag, "/early_done"}, DW'(dn), DW'(0));
        chk({tag, "/done"}, DW'(o_done), DW'(1));
        chk({tag, "/busy_in_done"}, DW'(o_busy), DW'(0));
        chk({tag, "/data"}, o_data, last_exp);
        chk({tag, "/mode"}, DW'(o_mode), DW'(mode));
        chk({tag, "/nbits"}, DW'(o_nbits), DW'(n));
    endtask

    task automatic hold_check(input string tag);
        i_valid = 1'b0;
        @(negedge clk);
        chk({tag, "/done_fell"}, DW'(o_done), DW'(0));
        chk({tag, "/idle_busy"}, DW'(o_busy), DW'(0));
        repeat (3) @(negedge clk);
        chk({tag, "/held"}, o_data, last_exp);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "/busy"}, DW'(o_busy), DW'(0));
        chk({tag, "/done"}, DW'(o_done), DW'(0));
        chk({tag, "/mode"}, DW'(o_mode), DW'(2'b11));
        chk({tag, "/nbits"}, DW'(o_nbits), DW'(128));
        chk({tag, "/data"}, o_data, '0);
    endtask

    initial begin
        int dn;
        int bsy;
        logic [1:0] m;
        rst     = 1'b0;
        i_valid = 1'b0;
        i_mode  = 1'b0;
        i_lane  = '0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b1;
        @(negedge clk);

        fv[0] = 128'hBEEF; fv[1] = 128'hFFF1; fv[2] = 128'h1234;
        fv[3] = 128'h0F0F; fv[4] = 128'h8001;
        run_frame(2'b00, 1'b0, "f16");
        hold_check("f16");

        for (int k = 0; k < NL; k++) fv[k] = {1'b1, 126'd0, 1'b1};
        run_frame(2'b11, 1'b0, "f128");
        hold_check("f128");

        for (int k = 0; k < NL; k++) fv[k] = rand_word() | {64'd0, 64'hFFFF_FFFF_0000_0000};
        run_frame(2'b10, 1'b0, "f64");
        hold_check("f64");
        for (int k = 0; k < NL; k++) fv[k] = rand_word();
        fv[0] = 128'hDEAD_BEEF;
        run_frame(2'b01, 1'b0, "f32_after_64");
        hold_check("f32_after_64");

        for (int k = 0; k < NL; k++) fv[k] = rand_word();
        run_frame(2'b01, 1'b1, "f32_glitch");
        hold_check("f32_glitch");

        for (int k = 0; k < NL; k++) fv[k] = rand_word();
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        i_mode  = 1'b1;
        @(negedge clk);
        i_mode = 1'b0;
        @(negedge clk);
        for (int i = 63; i > 53; i--) begin
            for (int k = 0; k < NL; k++) i_lane[k] = fv[k][i];
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        rst = 1'b1;
        dn  = 0;
        bsy = 0;
        repeat (70) begin
            i_lane = NL'($urandom);
            @(negedge clk);
            dn  += int'(o_done);
            bsy += int'(o_busy);
        end
        chk("midreset/no_done", DW'(dn), DW'(0));
        chk("midreset/no_busy", DW'(bsy), DW'(0));
        fv[0] = 128'h1357; fv[1] = 128'h2468; fv[2] = 128'hACE0;
        fv[3] = 128'h0001; fv[4] = 128'hFFFF;
        run_frame(2'b00, 1'b0, "f16_after_reset");
        hold_check("f16_after_reset");

        for (int k = 0; k < NL; k++) fv[k] = rand_word();
        run_frame(2'b01, 1'b0, "b2b_first");
        for (int k = 0; k < NL; k++) fv[k] = rand_word();
        run_frame(2'b10, 1'b0, "b2b_second");
        hold_check("b2b_second");

        for (int t = 0; t < 10; t++) begin
            m = 2'($urandom_range(0, 3));
            for (int k = 0; k < NL; k++) fv[k] = rand_word();
            run_frame(m, 1'($urandom), $sformatf("rnd%0d", t));
            if ($urandom_range(0, 1) == 0) begin
                hold_check($sformatf("rnd%0d", t));
            end
        end
        hold_check("final");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ecc_serial_rx.md
Name: ecc_serial_rx

Overview:
- Bit-serial frame receiver at the input of the ECC core.
- Accepts the host's serial protocol: a one-cycle start pulse, a 2-bit key-length mode sent MSB first, then N cycles of parallel data lanes (a, prime, Px, Py, m), each sent MSB first.
- Deserializes the lanes into right-aligned, zero-extended MAX_BITS words, decodes the operand length, and signals frame completion to the point-multiplication controller.
- Twin of the core's serial result transmitter.

Parameters:
- MAX_BITS, 128, width of each deserialized word; must be ≥ 128.
- LANES, 5, number of serial data lanes, in order a, prime, Px, Py, m.

Ports:
- clk  input  1  system clock; all sampling on rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_valid  input  1  frame start pulse; one cycle wide.
- i_mode  input  1  serial mode bit; meaningful only in the two cycles after the start pulse.
- i_lane  input  LANES  serial data bits, one per lane; bit 0 = a … bit 4 = m.
- o_busy  output  1  high while a frame is being received (MODE1, MODE0, SHIFT).
- o_done  output  1  one-cycle pulse: all words are complete and stable.
- o_mode  output  2  latched mode: 00=16, 01=32, 10=64, 11=128 bits.
- o_nbits  output  8  decoded length: 16, 32, 64 or 128.
- o_data  output  LANES*MAX_BITS  deserialized words; lane k occupies [k*MAX_BITS +: MAX_BITS].

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, o_busy=0, o_done=0, o_mode=2'b11, o_nbits=128, o_data=0, bit counter=0.
- FSM states: IDLE, MODE1, MODE0, SHIFT, DONE.
- IDLE:
  - i_valid=1 → MODE1.
  - On that same edge, clear every o_data word to 0.
- MODE1: latch i_mode into o_mode[1] → MODE0.
- MODE0:
  - Latch i_mode into o_mode[0] and update o_nbits.
  - Load counter with N-1 (N from the new mode) → SHIFT.
- SHIFT:
  - Every edge, each lane word shifts left by 1 with i_lane[k] inserted at bit 0.
  - Counter decrements.
  - On the edge where counter==0, sample the last bit → DONE.
- DONE:
  - o_done=1 for exactly this one cycle.
  - Next state is IDLE, or MODE1 if i_valid=1 in this cycle; in that case o_data is cleared on the same edge, so consumers must capture o_data while o_done=1.
- Latency:
  - Start pulse sampled at edge t0.
  - Mode bits sampled at t1 and t2.
  - Data bits sampled at t3 … t3+N-1.
  - o_done is high during the cycle after edge t3+N-1, i.e. 3+N cycles after t0.
- Result format: after N bits the MSB-first value is right-aligned in bits [N-1:0]; bits [MAX_BITS-1:N] are 0.
- o_data, o_mode and o_nbits hold after DONE until the next accepted start pulse.
- i_valid while in MODE1, MODE0 or SHIFT: ignored. There is no abort and no restart.
- X/undefined on i_mode outside MODE1/MODE0 and on i_lane outside SHIFT: must not affect any state.
- Reset asserted mid-frame: immediate return to reset values, and the partial frame is discarded.
- o_busy is registered and is 1 exactly in MODE1, MODE0 and SHIFT.
- o_done and o_busy are never both 1.

Decomposition:
- Shared package/header (the existing ECC define header): MAX_BITS, mode encodings BITS16/32/64/128, and the mode-to-length decode function.
- One natural sub-module: ecc_shift_lane, a single MAX_BITS shift register with clear and shift-enable, instantiated LANES times.
- The FSM and counter stay in the top module.

Test Plan:
- 16-bit frame: mode 00; a=0xBEEF, prime=0xFFF1, Px=0x1234, Py=0x0F0F, m=0x8001 → o_done 19 cycles after the start edge; words equal those values zero-extended to 128 bits; o_nbits=16.
- 128-bit frame: mode 11; all lanes carry 0x8000…0001 → o_done after 131 cycles; each word matches exactly; o_busy high for 130 cycles.
- 32-bit frame right after a 64-bit frame: stale upper bits of the 64-bit words are cleared; a=0xDEADBEEF reads back as 0x…00DEADBEEF.
- i_valid pulse mid-SHIFT on a 32-bit frame, and X on i_mode during SHIFT → frame completes unaffected; results match golden values; one o_done only.
- rst pulsed low for 1 cycle at bit 10 of a 64-bit frame → outputs return to reset values with no o_done; a following 16-bit frame decodes correctly.
- Back-to-back: i_valid high in the DONE cycle → new frame starts; previous o_data is valid only during that o_done cycle; second frame's o_done arrives 3+N cycles later.
